// File: rtl/fsel_pkg.sv
// Shared types, default parameters and bus helpers for the filter-select arbiter.
package fsel_pkg;

    typedef enum logic [1:0] {
        FSEL_HOLD     = 2'd0,
        FSEL_DEBOUNCE = 2'd1,
        FSEL_BLANK    = 2'd2
    } fsel_state_e;

    localparam int unsigned FSEL_N_SRC_DEF     = 2;
    localparam int unsigned FSEL_SEL_W_DEF     = 2;
    localparam int unsigned FSEL_DEBOUNCE_DEF  = 4;
    localparam int unsigned FSEL_BLANK_DEF     = 2;
    localparam int unsigned FSEL_SAFE_CODE_DEF = 0;

    // Widest code and widest flattened bus the slice helper handles (8 sources x 8 bits).
    localparam int unsigned FSEL_SEL_MAX = 8;
    localparam int unsigned FSEL_BUS_MAX = 64;

    localparam int unsigned FSEL_STAT_W = 16;

    // Extract source idx's code from a zero-extended flattened bus.
    function automatic logic [FSEL_SEL_MAX-1:0] fsel_slice(
        input logic [FSEL_BUS_MAX-1:0] bus,
        input int unsigned             idx,
        input int unsigned             sel_w
    );
        logic [FSEL_BUS_MAX-1:0] shifted;
        logic [FSEL_SEL_MAX-1:0] mask;
        shifted = bus >> (idx * sel_w);
        mask    = (sel_w >= FSEL_SEL_MAX) ? '1 : FSEL_SEL_MAX'((1 << sel_w) - 1);
        return FSEL_SEL_MAX'(shifted) & mask;
    endfunction

endpackage

// File: rtl/fsel_priority_enc.sv
// Highest-index request encoder; source 0 is always eligible.
module fsel_priority_enc
    import fsel_pkg::*;
#(
    parameter int unsigned N_SRC = FSEL_N_SRC_DEF
) (
    input  logic [N_SRC-1:0]         src_req,
    output logic [$clog2(N_SRC)-1:0] cand_c
);

    localparam int unsigned IDX_W = $clog2(N_SRC);

    logic [N_SRC-1:0] req_eff;

    assign req_eff = src_req | N_SRC'(1);

    // Ascending scan so the highest set bit wins.
    always_comb begin
        cand_c = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (req_eff[i]) begin
                cand_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/filter_select_arbiter.sv
// Debounced priority arbiter driving the sensor-filter select code, with a
// safe-code blanking interval on every switchover.
// Optional: define FSEL_ARB_STATS_EN to add switch_count / abort_count outputs.
module filter_select_arbiter
    import fsel_pkg::*;
#(
    parameter int unsigned       N_SRC        = FSEL_N_SRC_DEF,
    parameter int unsigned       SEL_W        = FSEL_SEL_W_DEF,
    parameter int unsigned       DEBOUNCE_CYC = FSEL_DEBOUNCE_DEF,
    parameter int unsigned       BLANK_CYC    = FSEL_BLANK_DEF,
    parameter logic [SEL_W-1:0]  SAFE_CODE    = SEL_W'(FSEL_SAFE_CODE_DEF)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC-1:0]         src_req,
    input  logic [N_SRC*SEL_W-1:0]   src_sel,
    output logic [SEL_W-1:0]         filter_select_out,
    output logic [$clog2(N_SRC)-1:0] active_src,
    output logic                     switching
`ifdef FSEL_ARB_STATS_EN
    ,
    output logic [FSEL_STAT_W-1:0]   switch_count,
    output logic [FSEL_STAT_W-1:0]   abort_count
`endif
);

    localparam int unsigned IDX_W   = $clog2(N_SRC);
    localparam int unsigned CNT_MAX = (DEBOUNCE_CYC > BLANK_CYC) ? DEBOUNCE_CYC : BLANK_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'((DEBOUNCE_CYC > 0) ? DEBOUNCE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    fsel_state_e             state;
    fsel_state_e             state_n;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_n;
    logic [IDX_W-1:0]        target;
    logic [IDX_W-1:0]        target_n;
    logic [IDX_W-1:0]        active_n;
    logic [SEL_W-1:0]        out_n;
    logic                    switching_n;
    logic [IDX_W-1:0]        cand_c;
    logic [FSEL_BUS_MAX-1:0] sel_bus;
    logic                    commit_c;
    logic                    abort_c;

    assign sel_bus = FSEL_BUS_MAX'(src_sel);

    fsel_priority_enc #(
        .N_SRC (N_SRC)
    ) u_enc (
        .src_req (src_req),
        .cand_c  (cand_c)
    );

    // Next-state, counter, target and output-code selection.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        target_n = target;
        active_n = active_src;
        out_n    = SEL_W'(fsel_slice(sel_bus, 32'(active_src), SEL_W));
        commit_c = 1'b0;
        abort_c  = 1'b0;

        case (state)
            FSEL_HOLD: begin
                if (cand_c != active_src) begin
                    target_n = cand_c;
                    cnt_n    = '0;
                    if (DEBOUNCE_CYC == 0) begin
                        if (BLANK_CYC == 0) begin
                            commit_c = 1'b1;
                            active_n = cand_c;
                            out_n    = SEL_W'(fsel_slice(sel_bus, 32'(cand_c), SEL_W));
                        end else begin
                            state_n = FSEL_BLANK;
                            out_n   = SAFE_CODE;
                        end
                    end else begin
                        state_n = FSEL_DEBOUNCE;
                    end
                end
            end

            FSEL_DEBOUNCE: begin
                if (cand_c == active_src) begin
                    // Request withdrawn before it settled.
                    state_n = FSEL_HOLD;
                    cnt_n   = '0;
                    abort_c = 1'b1;
                end else if (cand_c != target) begin
                    target_n = cand_c;
                    cnt_n    = '0;
                end else if (cnt == DEB_LAST) begin
                    cnt_n = '0;
                    if (BLANK_CYC == 0) begin
                        commit_c = 1'b1;
                        state_n  = FSEL_HOLD;
                        active_n = target;
                        out_n    = SEL_W'(fsel_slice(sel_bus, 32'(target), SEL_W));
                    end else begin
                        state_n = FSEL_BLANK;
                        out_n   = SAFE_CODE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            FSEL_BLANK: begin
                // Target is frozen; requests are not looked at here.
                out_n = SAFE_CODE;
                if (cnt == BLK_LAST) begin
                    cnt_n    = '0;
                    commit_c = 1'b1;
                    state_n  = FSEL_HOLD;
                    active_n = target;
                    out_n    = SEL_W'(fsel_slice(sel_bus, 32'(target), SEL_W));
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_n = FSEL_HOLD;
                cnt_n   = '0;
            end
        endcase

        switching_n = (state_n != FSEL_HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= FSEL_HOLD;
            cnt               <= '0;
            target            <= '0;
            active_src        <= '0;
            filter_select_out <= SAFE_CODE;
            switching         <= 1'b0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            target            <= target_n;
            active_src        <= active_n;
            filter_select_out <= out_n;
            switching         <= switching_n;
        end
    end

`ifdef FSEL_ARB_STATS_EN
    logic [FSEL_STAT_W-1:0] switch_count_n;
    logic [FSEL_STAT_W-1:0] abort_count_n;

    // Saturating event counters.
    always_comb begin
        switch_count_n = switch_count;
        abort_count_n  = abort_count;
        if (commit_c && (switch_count != '1)) begin
            switch_count_n = switch_count + FSEL_STAT_W'(1);
        end
        if (abort_c && (abort_count != '1)) begin
            abort_count_n = abort_count + FSEL_STAT_W'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            switch_count <= '0;
            abort_count  <= '0;
        end else begin
            switch_count <= switch_count_n;
            abort_count  <= abort_count_n;
        end
    end
`endif

endmodule

// File: tb/tb_filter_select_arbiter.sv
// Scoreboard bench for filter_select_arbiter (N_SRC=2, SEL_W=2, DEBOUNCE=4, BLANK=2).
module tb_filter_select_arbiter;

    localparam int N  = 2;
    localparam int W  = 2;
    localparam int D  = 4;
    localparam int B  = 2;
    localparam logic [1:0] SAFE = 2'b00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] src_req = 2'b00;
    logic [3:0] src_sel = 4'b1001;
    logic [1:0] filter_select_out;
    logic [0:0] active_src;
    logic       switching;
`ifdef FSEL_ARB_STATS_EN
    logic [15:0] switch_count;
    logic [15:0] abort_count;
`endif

    always #5 clk = ~clk;

    filter_select_arbiter #(
        .N_SRC        (N),
        .SEL_W        (W),
        .DEBOUNCE_CYC (D),
        .BLANK_CYC    (B),
        .SAFE_CODE    (SAFE)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .src_req           (src_req),
        .src_sel           (src_sel),
        .filter_select_out (filter_select_out),
        .active_src        (active_src),
        .switching         (switching)
`ifdef FSEL_ARB_STATS_EN
        ,
        .switch_count      (switch_count),
        .abort_count       (abort_count)
`endif
    );

    typedef struct packed {
        logic [1:0]  out;
        logic        act;
        logic        sw;
        logic [15:0] sc;
        logic [15:0] ac;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: a switch is a timeline measured in edges since the
    // candidate first differed from the active source.
    int         m_active = 0;
    int         m_pend   = -1;
    int         m_age    = 0;
    int         m_blank  = 0;
    logic [1:0] m_out    = SAFE;
    logic       m_sw     = 1'b0;
    int         m_sc     = 0;
    int         m_ac     = 0;

    function automatic logic [1:0] code_of(input logic [3:0] sel, input int idx);
        return sel[idx*2 +: 2];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_commit(input logic [3:0] sel);
        m_active = m_pend;
        m_pend   = -1;
        m_out    = code_of(sel, m_active);
        m_sw     = 1'b0;
        if (m_sc < 16'hFFFF) m_sc++;
    endtask

    task automatic model_step(input logic r, input logic [1:0] req, input logic [3:0] sel);
        int cand;
        if (r) begin
            m_active = 0; m_pend = -1; m_age = 0; m_blank = 0;
            m_out = SAFE; m_sw = 1'b0; m_sc = 0; m_ac = 0;
            return;
        end
        cand = 0;
        for (int i = 1; i < N; i++) if (req[i]) cand = i;
        if (m_blank > 0) begin
            m_blank--;
            if (m_blank == 0) model_commit(sel);
            else begin m_out = SAFE; m_sw = 1'b1; end
        end else if (cand == m_active) begin
            if (m_pend >= 0 && m_ac < 16'hFFFF) m_ac++;
            m_pend = -1;
            m_out  = code_of(sel, m_active);
            m_sw   = 1'b0;
        end else begin
            if (cand != m_pend) begin m_pend = cand; m_age = 1; end
            else m_age++;
            if (m_age == D + 1) begin
                if (B == 0) model_commit(sel);
                else begin m_blank = B; m_out = SAFE; m_sw = 1'b1; end
            end else begin
                m_out = code_of(sel, m_active);
                m_sw  = 1'b1;
            end
        end
    endtask

    // Drive one cycle of stimulus and queue the response expected after the next edge.
    task automatic step(input logic r, input logic [1:0] req, input logic [1:0] c0, input logic [1:0] c1);
        exp_t e;
        @(negedge clk);
        rst     = r;
        src_req = req;
        src_sel = {c1, c0};
        model_step(r, req, {c1, c0});
        e.out = m_out;
        e.act = 1'(m_active);
        e.sw  = m_sw;
        e.sc  = 16'(m_sc);
        e.ac  = 16'(m_ac);
        q.push_back(e);
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare every registered output against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sb_out", int'(filter_select_out), int'(e.out));
                check("sb_active", int'(active_src), int'(e.act));
                check("sb_switching", int'(switching), int'(e.sw));
`ifdef FSEL_ARB_STATS_EN
                check("sb_switch_count", int'(switch_count), int'(e.sc));
                check("sb_abort_count", int'(abort_count), int'(e.ac));
`endif
            end
        end
    end

    logic [1:0] exp_clean [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
    logic       exp_sw    [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int         hold;
        logic       r;
        logic [1:0] req;

        // Reset for three cycles, then release.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b00, 2'b01, 2'b10);
            sample();
            check("reset_out", int'(filter_select_out), 0);
            check("reset_switching", int'(switching), 0);
        end
        step(1'b0, 2'b00, 2'b01, 2'b10);
        sample();
        check("release_out", int'(filter_select_out), 1);
        check("release_active", int'(active_src), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 2'b01, 2'b10);

        // Clean switch to source 1.
        for (int j = 0; j < 7; j++) begin
            step(1'b0, 2'b10, 2'b01, 2'b10);
            sample();
            check("clean_out", int'(filter_select_out), int'(exp_clean[j]));
            check("clean_switching", int'(switching), int'(exp_sw[j]));
        end
        check("clean_active", int'(active_src), 1);

        // Tracking of the active source, one-cycle latency.
        step(1'b0, 2'b10, 2'b01, 2'b11); sample();
        check("track_11", int'(filter_select_out), 3);
        step(1'b0, 2'b10, 2'b01, 2'b01); sample();
        check("track_01", int'(filter_select_out), 1);
        step(1'b0, 2'b10, 2'b01, 2'b10); sample();
        check("track_10", int'(filter_select_out), 2);

        // Switch back to source 0.
        for (int i = 0; i < 9; i++) step(1'b0, 2'b00, 2'b01, 2'b10);
        sample();
        check("back_active", int'(active_src), 0);

        // Three-cycle glitch must be rejected.
        for (int i = 0; i < 9; i++) begin
            step(1'b0, (i < 3) ? 2'b10 : 2'b00, 2'b01, 2'b10);
            sample();
            check("glitch_out", int'(filter_select_out), 1);
        end
`ifdef FSEL_ARB_STATS_EN
        check("glitch_abort_count", int'(abort_count), 1);
`endif

        // Reset in the first blanking cycle aborts the switch.
        for (int i = 0; i < 5; i++) step(1'b0, 2'b10, 2'b01, 2'b10);
        sample();
        check("pre_reset_safe", int'(filter_select_out), 0);
        step(1'b1, 2'b10, 2'b01, 2'b10);
        sample();
        check("midreset_out", int'(filter_select_out), 0);
        check("midreset_active", int'(active_src), 0);
        for (int i = 0; i < 10; i++) step(1'b0, 2'b00, 2'b01, 2'b10);
        sample();
        check("midreset_no_commit", int'(active_src), 0);

        // Three alternating clean switches from a fresh reset.
        step(1'b1, 2'b00, 2'b01, 2'b10);
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 10; i++) step(1'b0, (s == 1) ? 2'b00 : 2'b10, 2'b01, 2'b10);
        sample();
        check("stats_end_active", int'(active_src), 1);
`ifdef FSEL_ARB_STATS_EN
        check("stats_switch_count", int'(switch_count), 3);
`endif

        // Randomised request holds, codes and occasional reset.
        for (int c = 0; c < 600; c += hold) begin
            hold = $urandom_range(1, 9);
            req  = 2'($urandom_range(0, 3));
            for (int h = 0; h < hold; h++) begin
                r = ($urandom_range(0, 60) == 0);
                step(r, {req[1], 1'($urandom_range(0, 1))},
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            end
        end

        // Drain the scoreboard.
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_select_arbiter.md
# filter_select_arbiter

Registered, parametrised arbiter that drives the filter-select code consumed by the sensor-filter stage from one of `N_SRC` mode controllers, e.g. balance and identify. It replaces the single-bit `ready` two-way choice with priority arbitration. A requesting source must hold its request stable for a debounce window before it takes over. Every switchover is followed by a blanking interval on a safe code, so the filter never sees a glitch or a mid-switch mixed code.

## Interface
Parameters:
- `N_SRC`, default 2: number of mode sources; 2..8.
- `SEL_W`, default 2: width of each filter-select code.
- `DEBOUNCE_CYC`, default 4: cycles a new winner must stay stable before switching; 0 is legal.
- `BLANK_CYC`, default 2: cycles `SAFE_CODE` is driven during a switchover; 0 is legal.
- `SAFE_CODE`, default 0: code driven during reset and blanking.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. Synchronous and active-high; one clock; clock and reset named as elsewhere in the codebase.
- `src_req`, in, `N_SRC`: per-source request. Bit 0 is ignored and treated as 1, so source 0 is the always-eligible default.
- `src_sel`, in, `N_SRC*SEL_W`: flattened codes; source i occupies bits `[i*SEL_W +: SEL_W]`.
- `filter_select_out`, out, `SEL_W`: registered selected code.
- `active_src`, out, `$clog2(N_SRC)`: index of the source currently driving the output.
- `switching`, out, 1: high while the state is DEBOUNCE or BLANK.

## Operation
- Candidate: the highest index i with `src_req[i]`=1. Source 0 is the candidate when no other bit is set.
- State HOLD: `filter_select_out` <= `src_sel` of `active_src`, re-sampled every cycle.
  - If candidate != `active_src`: latch `target` <= candidate and clear the counter.
  - If `DEBOUNCE_CYC`=0, go to BLANK, or straight to COMMIT when `BLANK_CYC`=0.
  - Otherwise go to DEBOUNCE.
- State DEBOUNCE: the output keeps tracking the active source.
  - Candidate == `active_src`: return to HOLD (request withdrawn).
  - Candidate != `target`: `target` <= candidate, counter <= 0, stay in DEBOUNCE.
  - Otherwise counter++. When counter reaches `DEBOUNCE_CYC`-1, go to BLANK, or COMMIT when `BLANK_CYC`=0.
- State BLANK: output <= `SAFE_CODE` for exactly `BLANK_CYC` cycles. Request changes are ignored and `target` is frozen. Then go to COMMIT.
- COMMIT is a single-cycle action, not a state: `active_src` <= `target`, the output takes the new source's code, and the state becomes HOLD. Arbitration resumes on the next cycle.
- Counters are `$clog2(max(DEBOUNCE_CYC,BLANK_CYC)+1)` bits wide and never wrap. Counting stops at the terminal value.

## Timing
- Reset values: `filter_select_out`=`SAFE_CODE`, `active_src`=0, `switching`=0, state HOLD, counters 0.
- Reset asserted mid-debounce or mid-blank aborts the switch immediately. The block then shows the reset values on the next edge.
- First cycle after reset release: the output takes source 0's code; latency 1.
- Steady-state latency from `src_sel` of the active source to the output: 1 cycle.
- Switch latency: a candidate that changes at edge k and stays stable produces the new source's code at edge k+`DEBOUNCE_CYC`+`BLANK_CYC`+1.
- Blanking is preceded by `DEBOUNCE_CYC` cycles of the old code.
- `switching` rises with the DEBOUNCE (or BLANK) entry edge and falls at the COMMIT edge.
- If a request toggles faster than `DEBOUNCE_CYC`, no switch ever occurs.
- A candidate change during BLANK still commits the frozen `target`. A new arbitration starts from HOLD on the next cycle.

## Configuration
- `FSEL_ARB_STATS_EN` defined:
  - Adds output `switch_count`, 16 bits, reset 0.
  - Increments on each COMMIT and saturates at 0xFFFF.
  - Adds output `abort_count`, 16 bits, saturating. It counts DEBOUNCE exits back to HOLD caused by withdrawn requests.
- Macro undefined: both ports and their logic are absent. All other behaviour is identical.

## Structure
- Package `fsel_pkg`:
  - State enum: `FSEL_HOLD`, `FSEL_DEBOUNCE`, `FSEL_BLANK`.
  - Default-parameter localparams.
  - Function `fsel_slice` for extracting a source code from the flattened bus.
- Sub-module `fsel_priority_enc`: combinational highest-index encoder from `src_req` (bit 0 forced to 1) to the candidate index.
- The top contains the FSM, counters, output register and the optional stats.

## Test plan
Bench parameters: `N_SRC`=2, `SEL_W`=2, `DEBOUNCE_CYC`=4, `BLANK_CYC`=2, `SAFE_CODE`=0. Source 0 code = 2'b01, source 1 code = 2'b10.
- Reset: hold `rst` for 3 cycles, then release. Output = 0 during reset, then 2'b01 one cycle after release; `active_src`=0.
- Clean switch: `src_req[1]` rises at edge k and is held. Output is 01 through edge k+4, 00 at edges k+5..k+6, then 10 at edge k+7 with `active_src`=1; `switching` is high from k+1 to k+6.
- Glitch rejection: pulse `src_req[1]` high for 3 cycles. Output never leaves 01; `switching` pulses high; with stats enabled, `abort_count`=1.
- Mid-switch reset: assert `rst` in the first BLANK cycle. The next edge shows output 0, `active_src`=0, and no commit afterwards.
- Tracking and latency: while active, step source 1's code 10 -> 11 -> 01. The output follows each step one cycle later.
- Stats (macro defined): perform 3 clean switches in alternating directions. `switch_count`=3.
